// File: rtl/mc_ctrl.sv
// mc_ctrl: five-state multi-cycle control sequencer sharing one memory port between fetch and data access
module mc_ctrl #(
  parameter logic ADDR_SEL_PC = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        rs_eq_rt,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        reg_dst_rd,
  output logic [2:0]  state,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic [5:0]  op;
  logic        is_r, is_j, is_beq, is_lui, is_lw, is_sw, is_andi;
  logic        unused_inst;

  assign op          = inst[31:26];
  assign unused_inst = ^inst[25:0];
  assign is_r        = op == 6'h00;
  assign is_j        = op == 6'h02 || op == 6'h03;
  assign is_beq      = op == 6'h04;
  assign is_lui      = op == 6'h0F;
  assign is_lw       = op == 6'h23;
  assign is_sw       = op == 6'h2B;
  assign is_andi     = op == 6'h0C;

  // Per-state strobes, next state and retire; everything is forced quiet while reset is held
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_SEL_PC;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src_b    = 1'b0;
    alu_op       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    reg_dst_rd   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        pc_we   = is_j;
        pc_src  = is_j ? 2'b10 : 2'b00;
        retire  = is_j;
        state_d = is_j ? FETCH : EXEC;
      end
      EXEC: begin
        alu_src_b = !is_r;
        alu_op    = is_andi;
        pc_we     = is_beq && rs_eq_rt;
        pc_src    = is_beq ? 2'b01 : 2'b00;
        retire    = is_beq;
        state_d   = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_we       = is_sw;
        mem_addr_sel = ~ADDR_SEL_PC;
        if (mem_ready) begin
          mdr_we  = !is_sw;
          retire  = is_sw;
          state_d = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        wb_sel     = is_lw ? 2'b01 : is_lui ? 2'b10 : 2'b00;
        reg_dst_rd = is_r;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 1'b0;
      alu_op     = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = 2'b00;
      reg_dst_rd = 1'b0;
    end
    instret_d = instret_q + {31'd0, retire};
  end

  // State and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed cycle-by-cycle check of mc_ctrl strobes, state and instret
module tb_mc_ctrl;
  logic        clk, rst_n, mem_ready, rs_eq_rt;
  logic [31:0] inst;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_src_b, alu_op, reg_we, reg_dst_rd;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [13:0] obs;
  int          checks = 0;
  int          failures = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready), .rs_eq_rt(rs_eq_rt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .reg_dst_rd(reg_dst_rd),
    .state(state), .instret(instret)
  );

  // strobe vector: req we asel irwe mdrwe pcwe pcsrc[2] asrcb aluop regwe wbsel[2] dst
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src,
                alu_src_b, alu_op, reg_we, wb_sel, reg_dst_rd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic eq,
                     input logic [2:0] st, input logic [13:0] exp);
    mem_ready = rdy;
    rs_eq_rt  = eq;
    #1;
    chk({tag, ".st"}, 32'(state), 32'(st));
    chk({tag, ".strb"}, 32'(obs), 32'(exp));
    @(negedge clk);
  endtask

  localparam logic [13:0] F_WAIT = 14'b1_0_0_0_0_0_00_0_0_0_00_0;
  localparam logic [13:0] F_RDY  = 14'b1_0_0_1_0_1_00_0_0_0_00_0;
  localparam logic [13:0] IDLE   = 14'b0_0_0_0_0_0_00_0_0_0_00_0;
  localparam logic [13:0] EX_IMM = 14'b0_0_0_0_0_0_00_1_0_0_00_0;
  localparam logic [13:0] M_WAIT = 14'b1_0_1_0_0_0_00_0_0_0_00_0;
  localparam logic [13:0] M_LW   = 14'b1_0_1_0_1_0_00_0_0_0_00_0;
  localparam logic [13:0] M_SW   = 14'b1_1_1_0_0_0_00_0_0_0_00_0;
  localparam logic [13:0] WB_LW  = 14'b0_0_0_0_0_0_00_0_0_1_01_0;
  localparam logic [13:0] WB_LUI = 14'b0_0_0_0_0_0_00_0_0_1_10_0;
  localparam logic [13:0] WB_R   = 14'b0_0_0_0_0_0_00_0_0_1_00_1;
  localparam logic [13:0] WB_I   = 14'b0_0_0_0_0_0_00_0_0_1_00_0;
  localparam logic [13:0] EX_BT  = 14'b0_0_0_0_0_1_01_1_0_0_00_0;
  localparam logic [13:0] EX_BN  = 14'b0_0_0_0_0_0_01_1_0_0_00_0;
  localparam logic [13:0] EX_AND = 14'b0_0_0_0_0_0_00_1_1_0_00_0;
  localparam logic [13:0] D_J    = 14'b0_0_0_0_0_1_10_0_0_0_00_0;

  initial begin
    rst_n = 1'b0; inst = 32'h0; mem_ready = 1'b1; rs_eq_rt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.st", 32'(state), 32'd0);
    chk("rst.strb", 32'(obs), 32'(IDLE));
    chk("rst.instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // lw with two wait cycles in FETCH and in MEM
    inst = 32'h8C820004;
    cyc("lw.f0", 1'b0, 1'b0, 3'd0, F_WAIT);
    cyc("lw.f1", 1'b0, 1'b0, 3'd0, F_WAIT);
    cyc("lw.f2", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("lw.d",  1'b1, 1'b0, 3'd1, IDLE);
    cyc("lw.e",  1'b1, 1'b0, 3'd2, EX_IMM);
    cyc("lw.m0", 1'b0, 1'b0, 3'd3, M_WAIT);
    cyc("lw.m1", 1'b0, 1'b0, 3'd3, M_WAIT);
    cyc("lw.m2", 1'b1, 1'b0, 3'd3, M_LW);
    cyc("lw.wb", 1'b1, 1'b0, 3'd4, WB_LW);
    chk("lw.instret", instret, 32'd1);
    // sw zero-wait
    inst = 32'hAC820004;
    cyc("sw.f", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("sw.d", 1'b0, 1'b0, 3'd1, IDLE);
    cyc("sw.e", 1'b0, 1'b0, 3'd2, EX_IMM);
    cyc("sw.m", 1'b1, 1'b0, 3'd3, M_SW);
    chk("sw.instret", instret, 32'd2);
    // beq taken and not taken
    inst = 32'h10220003;
    cyc("beqt.f", 1'b1, 1'b1, 3'd0, F_RDY);
    cyc("beqt.d", 1'b0, 1'b1, 3'd1, IDLE);
    cyc("beqt.e", 1'b0, 1'b1, 3'd2, EX_BT);
    chk("beqt.instret", instret, 32'd3);
    cyc("beqn.f", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("beqn.d", 1'b0, 1'b0, 3'd1, IDLE);
    cyc("beqn.e", 1'b0, 1'b0, 3'd2, EX_BN);
    chk("beqn.instret", instret, 32'd4);
    // jump
    inst = 32'h08000010;
    cyc("j.f", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("j.d", 1'b0, 1'b0, 3'd1, D_J);
    chk("j.instret", instret, 32'd5);
    // lui
    inst = 32'h3C011234;
    cyc("lui.f",  1'b1, 1'b0, 3'd0, F_RDY);
    cyc("lui.d",  1'b0, 1'b0, 3'd1, IDLE);
    cyc("lui.e",  1'b0, 1'b0, 3'd2, EX_IMM);
    cyc("lui.wb", 1'b0, 1'b0, 3'd4, WB_LUI);
    // R-type add
    inst = 32'h00221820;
    cyc("r.f",  1'b1, 1'b0, 3'd0, F_RDY);
    cyc("r.d",  1'b0, 1'b0, 3'd1, IDLE);
    cyc("r.e",  1'b0, 1'b0, 3'd2, IDLE);
    cyc("r.wb", 1'b0, 1'b0, 3'd4, WB_R);
    // andi
    inst = 32'h304200FF;
    cyc("andi.f",  1'b1, 1'b0, 3'd0, F_RDY);
    cyc("andi.d",  1'b0, 1'b0, 3'd1, IDLE);
    cyc("andi.e",  1'b0, 1'b0, 3'd2, EX_AND);
    cyc("andi.wb", 1'b0, 1'b0, 3'd4, WB_I);
    // addi
    inst = 32'h20420001;
    cyc("addi.f",  1'b1, 1'b0, 3'd0, F_RDY);
    cyc("addi.d",  1'b0, 1'b0, 3'd1, IDLE);
    cyc("addi.e",  1'b0, 1'b0, 3'd2, EX_IMM);
    cyc("addi.wb", 1'b0, 1'b0, 3'd4, WB_I);
    chk("addi.instret", instret, 32'd9);
    // reset asserted mid-MEM
    inst = 32'hAC820004;
    cyc("rm.f", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("rm.d", 1'b0, 1'b0, 3'd1, IDLE);
    cyc("rm.e", 1'b0, 1'b0, 3'd2, EX_IMM);
    mem_ready = 1'b0;
    #1;
    chk("rm.mreq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm.st", 32'(state), 32'd0);
    chk("rm.strb", 32'(obs), 32'(IDLE));
    chk("rm.instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rm.f2", 1'b0, 1'b0, 3'd0, F_WAIT);
    // instret wrap on an R-type retire
    inst = 32'h00221820;
    cyc("wr.f", 1'b1, 1'b0, 3'd0, F_RDY);
    cyc("wr.d", 1'b0, 1'b0, 3'd1, IDLE);
    cyc("wr.e", 1'b0, 1'b0, 3'd2, IDLE);
    mem_ready = 1'b0;
    #1;
    chk("wr.wb", 32'(obs), 32'(WB_R));
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wr.pre", instret, 32'hFFFFFFFF);
    @(negedge clk);
    chk("wr.instret", instret, 32'd0);
    chk("wr.st", 32'(state), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
